// File: rtl/freq_pkg.sv
// Shared types and constants for the programmable square-wave generator.
package freq_pkg;

  localparam int unsigned F_W     = 17;
  localparam int unsigned F_MAX   = 99990;
  localparam int unsigned BCD_MAX = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_to_bin.sv
// Four-digit BCD plus decade range bit to binary frequency, with digit check.
module bcd_to_bin
  import freq_pkg::*;
(
  input  logic [15:0]    bcd,
  input  logic           range,
  output logic [F_W-1:0] value,
  output logic           digit_err
);

  logic [F_W-1:0] base;

  // Weighted digit sum; out-of-range digits only raise the flag.
  always_comb begin
    digit_err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] > 4'(BCD_MAX)) digit_err = 1'b1;
    end
    base  = F_W'(bcd[15:12]) * F_W'(1000) + F_W'(bcd[11:8]) * F_W'(100)
          + F_W'(bcd[7:4]) * F_W'(10) + F_W'(bcd[3:0]);
    value = range ? F_W'(base * F_W'(10)) : base;
  end

endmodule

// File: rtl/freq_gen.sv
// Fractional-accumulator square-wave generator with glitch-free retuning.
module freq_gen
  import freq_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned ACC_W  = 28
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] bcd_freq,
  input  logic        range,
  output logic        signal_out,
  output logic        rise_tick,
  output logic        running,
  output logic        cfg_err
);

  state_t           state, state_n;
  logic [ACC_W-1:0] acc, acc_n;
  logic [F_W-1:0]   active_f, active_n;
  logic [F_W-1:0]   pending_f, pending_n;
  logic             sig_n, tick_n, err_n;

  logic [F_W-1:0]   f_in;
  logic             digit_err;
  logic             accept;
  logic [31:0]      two_f;
  logic [ACC_W-1:0] sum;
  logic             wrap;
  logic             fall;

  bcd_to_bin u_conv (
    .bcd       (bcd_freq),
    .range     (range),
    .value     (f_in),
    .digit_err (digit_err)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      acc        <= '0;
      active_f   <= '0;
      pending_f  <= '0;
      signal_out <= 1'b0;
      rise_tick  <= 1'b0;
      running    <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state      <= state_n;
      acc        <= acc_n;
      active_f   <= active_n;
      pending_f  <= pending_n;
      signal_out <= sig_n;
      rise_tick  <= tick_n;
      running    <= (state_n != IDLE);
      cfg_err    <= err_n;
    end
  end

  // Next-state, accumulator stepping and load handling.
  always_comb begin
    state_n   = state;
    acc_n     = acc;
    active_n  = active_f;
    pending_n = pending_f;
    sig_n     = signal_out;
    tick_n    = 1'b0;
    err_n     = cfg_err;

    two_f  = 32'(f_in) << 1;
    accept = load && !digit_err && (two_f <= CLK_HZ);
    sum    = acc + ACC_W'({active_f, 1'b0});
    wrap   = (sum >= ACC_W'(CLK_HZ));
    fall   = wrap && signal_out;

    if (load) err_n = !accept;

    if (!enable) begin
      // Drop straight to idle; any queued setting takes effect now.
      state_n = IDLE;
      acc_n   = '0;
      sig_n   = 1'b0;
      if (state == PEND) active_n = pending_f;
      if (accept) begin
        active_n  = f_in;
        pending_n = f_in;
      end
    end else begin
      case (state)
        IDLE: begin
          acc_n = '0;
          sig_n = 1'b0;
          if (accept) begin
            active_n  = f_in;
            pending_n = f_in;
          end
          if (active_f != '0) state_n = RUN;
        end
        RUN, PEND: begin
          acc_n  = wrap ? ACC_W'(sum - ACC_W'(CLK_HZ)) : sum;
          sig_n  = wrap ? !signal_out : signal_out;
          tick_n = wrap && !signal_out;
          if (state == RUN) begin
            if (accept) begin
              pending_n = f_in;
              state_n   = PEND;
            end
          end else begin
            if (fall) begin
              // Swap settings only at a falling edge so no runt phase appears.
              acc_n    = '0;
              active_n = pending_f;
              state_n  = (pending_f == '0) ? IDLE : RUN;
            end
            if (accept) begin
              pending_n = f_in;
              if (fall) begin
                if (pending_f == '0) active_n = f_in;
                else state_n = PEND;
              end
            end
          end
        end
        default: begin
          state_n = IDLE;
          acc_n   = '0;
          sig_n   = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/freq_gen.md
Name: freq_gen

Overview:
- Programmable square-wave generator, the stimulus-side counterpart of the frequency meter.
- Takes a 4-digit BCD frequency (0–9999) plus a range bit (range=1 multiplies by 10), and produces a 50%-duty-nominal square wave at exactly that average frequency.
- Uses a fractional (accumulator) divider from the system clock.
- Sits on the board next to the meter; drives its signal input for self-test, and drives a pin for external use.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz; must be < 2^27.
- ACC_W, 28, accumulator width; must satisfy 2^ACC_W > CLK_HZ + 2*99990.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- enable  input  1  1 = generate; 0 = output held low.
- load  input  1  single-cycle strobe; latch bcd_freq/range as a new setting.
- bcd_freq  input  16  four BCD digits, [15:12] = thousands … [3:0] = units.
- range  input  1  0: f = value Hz; 1: f = value*10 Hz.
- signal_out  output  1  generated square wave.
- rise_tick  output  1  one-cycle pulse on the cycle signal_out goes 0→1.
- running  output  1  1 when state is RUN or PEND.
- cfg_err  output  1  sticky; set by a rejected load, cleared by the next accepted load.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - signal_out=0, rise_tick=0, running=0, cfg_err=0.
  - Accumulator=0, active_f=0, pending_f=0, state=IDLE.
  - Reset mid-run: all of the above on the next edge; the pending setting is discarded.
- Load validation (combinational from bcd_freq/range; registered at the load edge):
  - Any digit > 9 → rejected.
  - f = d3*1000 + d2*100 + d1*10 + d0, then ×10 if range=1 (17-bit, max 99990).
  - 2*f > CLK_HZ → rejected.
  - Rejected: cfg_err←1; active/pending settings and the output are unchanged.
  - Accepted: cfg_err←0; the value goes to pending_f.
- State IDLE (enable=0, or active_f=0):
  - signal_out=0, accumulator=0.
  - An accepted load becomes active_f on the next edge (latency 1).
  - If enable=1 and active_f≠0 → RUN.
- State RUN, every cycle:
  - sum = acc + 2*active_f.
  - If sum ≥ CLK_HZ: acc←sum−CLK_HZ and signal_out toggles; otherwise acc←sum.
  - This gives exactly active_f rising edges per CLK_HZ cycles on average; toggle interval jitter ≤ 1 clk.
  - rise_tick=1 on the cycle signal_out changes 0→1.
  - An accepted load → PEND.
- State PEND: accumulation continues with the old active_f. On the edge where signal_out toggles 1→0:
  - active_f←pending_f, acc←0.
  - Go to RUN, or to IDLE if the new f=0.
  - This guarantees no runt pulses.
- Further loads in PEND overwrite pending_f (last wins).
- Load on the same cycle as a 1→0 toggle: the toggle uses the old setting; the new value waits for the next falling toggle.
- enable→0 in any state: next edge signal_out=0, acc=0, state=IDLE. Any pending value becomes active immediately.
- rise_tick is never asserted in IDLE.
- running = (state≠IDLE).

Decomposition:
- Shared package freq_pkg:
  - state encoding IDLE/RUN/PEND (2-bit);
  - F_MAX=99990;
  - BCD digit limit 9;
  - F_W=17.
- Natural sub-module: bcd_to_bin, purely combinational. It takes 16-bit BCD plus range and outputs the 17-bit binary value plus a digit_err flag. The meter-side team reuses it for range checks.

Test Plan:
- Exact divide, CLK_HZ=1000: load 0x0005, range=0, enable=1 → signal_out toggles every 100 clk, period 200; rise_tick every 200 clk.
- Range bit, CLK_HZ=1000: load 0x0005, range=1 → 50 Hz; toggles every 10 clk; running=1.
- Fractional, CLK_HZ=1000, f=3:
  - exactly 3 rise_ticks in every 1000-clk window after the first edge;
  - high/low phase lengths are each 166 or 167 clk.
- Invalid BCD: load 0x00A1 while running at 5 Hz → cfg_err=1, waveform unchanged. A following valid load of 0x0002 → cfg_err=0.
- Glitch-free retune, CLK_HZ=1000: running at 5 Hz, load 0x0010 mid-high-phase →
  - old high phase completes (full 100 clk);
  - new 10 Hz waveform starts from the falling edge with acc=0;
  - no phase shorter than 50 clk.
- Reset/enable:
  - reset_n=0 mid-high → next edge signal_out=0, running=0, cfg_err=0.
  - Separately, enable=0 → signal_out=0 within 1 clk.
  - Load 0x0000 while idle → stays IDLE; signal_out=0 and no rise_tick, no matter how long enable stays high.
